// File: rtl/mips_multicycle_control_if.sv
// Control <-> datapath/memory bundle for the multicycle MIPS32 controller.
// exc exists only when MIPS_MC_CTRL_ILLEGAL_EXC_EN is defined.
interface mips_multicycle_control_if #(parameter int ALUCTL_W = 4);
  logic [5:0]          Opcode;
  logic [5:0]          funct;
  logic [4:0]          shamt;
  logic                mem_ready;
  logic                mem_req;
  logic                MemWrite;
  logic                IorD;
  logic                IRWrite;
  logic                PCWrite;
  logic                Branch;
  logic [1:0]          PCSrc;
  logic                ALUSrcA;
  logic [1:0]          ALUSrcB;
  logic [ALUCTL_W-1:0] ALUControl;
  logic                RegWrite;
  logic [1:0]          RegDst;
  logic [1:0]          MemToReg;
  logic                mem_err;
  logic [3:0]          state_o;
`ifdef MIPS_MC_CTRL_ILLEGAL_EXC_EN
  logic                exc;
`endif

  modport master (
    input  Opcode, funct, shamt, mem_ready,
    output mem_req, MemWrite, IorD, IRWrite, PCWrite, Branch, PCSrc,
           ALUSrcA, ALUSrcB, ALUControl, RegWrite, RegDst, MemToReg,
           mem_err, state_o
`ifdef MIPS_MC_CTRL_ILLEGAL_EXC_EN
    , output exc
`endif
  );

  modport slave (
    output Opcode, funct, shamt, mem_ready,
    input  mem_req, MemWrite, IorD, IRWrite, PCWrite, Branch, PCSrc,
           ALUSrcA, ALUSrcB, ALUControl, RegWrite, RegDst, MemToReg,
           mem_err, state_o
`ifdef MIPS_MC_CTRL_ILLEGAL_EXC_EN
    , input exc
`endif
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Moore-FSM control unit for a shared-memory multicycle MIPS32 datapath.
// Optional MIPS_MC_CTRL_ILLEGAL_EXC_EN: undecoded opcodes trap (state 15, exc).
module mips_multicycle_control #(
  parameter int ALUCTL_W    = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input logic                         clk,
  input logic                         rst_n,
  mips_multicycle_control_if.master   bus
);
  localparam logic [3:0] S_IDLE = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2,
                         S_MEMADR = 4'd3, S_MEMRD = 4'd4, S_MEMWB = 4'd5,
                         S_MEMWR = 4'd6, S_EXEC = 4'd7,   S_ALUWB = 4'd8,
                         S_BRANCH = 4'd9, S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
                         S_JAL = 4'd12,  S_JR = 4'd13,    S_HALT = 4'd14,
                         S_TRAP = 4'd15;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000,
                         OP_JAL = 6'b000011, OP_SP3 = 6'b011111;
  localparam logic [5:0] F_JR = 6'b001000;

  localparam logic [3:0] A_AND = 4'b0000, A_OR = 4'b0001, A_ADD = 4'b0010,
                         A_SUB = 4'b0110, A_SLT = 4'b0111,
                         A_QB = 4'b1000, A_QBS = 4'b1001;

  localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  logic [3:0]       st, nxt;
  logic [CNT_W-1:0] cnt;
  logic             err;
  logic             mem_wait, tmo;
  logic [3:0]       alu4;
  logic             alu_nop;

  // Function decode for EXEC/ALUWB; anything unrecognised is a NOP (no writeback)
  always_comb begin
    alu4    = A_AND;
    alu_nop = 1'b1;
    if (bus.Opcode == OP_R) begin
      alu_nop = 1'b0;
      case (bus.funct)
        6'b100000: alu4 = A_ADD;
        6'b100010: alu4 = A_SUB;
        6'b100100: alu4 = A_AND;
        6'b100101: alu4 = A_OR;
        6'b101010: alu4 = A_SLT;
        default:   alu_nop = 1'b1;
      endcase
    end else if (bus.Opcode == OP_SP3 && bus.funct == 6'b010000) begin
      if (bus.shamt == 5'd0) begin
        alu4 = A_QB;  alu_nop = 1'b0;
      end else if (bus.shamt == 5'd4) begin
        alu4 = A_QBS; alu_nop = 1'b0;
      end
    end
  end

  assign mem_wait = (st == S_FETCH || st == S_MEMRD || st == S_MEMWR) && !bus.mem_ready;
  assign tmo      = (MEM_TIMEOUT != 0) && mem_wait && (cnt == CNT_W'(MEM_TIMEOUT));

  always_comb begin
    nxt = st;
    case (st)
      S_IDLE:   nxt = S_FETCH;
      S_FETCH:  if (bus.mem_ready) nxt = S_DECODE;
      S_DECODE: begin
        case (bus.Opcode)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_R:         nxt = (bus.funct == F_JR) ? S_JR : S_EXEC;
          OP_SP3:       nxt = S_EXEC;
          OP_BEQ:       nxt = S_BRANCH;
          OP_ADDI:      nxt = S_ADDIEX;
          OP_JAL:       nxt = S_JAL;
`ifdef MIPS_MC_CTRL_ILLEGAL_EXC_EN
          default:      nxt = S_TRAP;
`else
          default:      nxt = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: nxt = (bus.Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (bus.mem_ready) nxt = S_MEMWB;
      S_MEMWR:  if (bus.mem_ready) nxt = S_FETCH;
      S_EXEC:   nxt = S_ALUWB;
      S_ADDIEX: nxt = S_ADDIWB;
      S_HALT:   nxt = S_HALT;
      default:  nxt = S_FETCH;
    endcase
    if (tmo) nxt = S_HALT;
  end

  // Counter restarts on any state change, so every memory-state entry sees zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st  <= S_IDLE;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      st <= nxt;
      if (nxt != st)     cnt <= '0;
      else if (mem_wait) cnt <= cnt + CNT_W'(1);
      if (tmo) err <= 1'b1;
    end
  end

  // IRWrite/PCWrite stay up for all of FETCH; the datapath qualifies them with mem_ready
  always_comb begin
    bus.mem_req    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IorD       = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.PCWrite    = 1'b0;
    bus.Branch     = 1'b0;
    bus.PCSrc      = 2'b00;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = 2'b00;
    bus.ALUControl = '0;
    bus.RegWrite   = 1'b0;
    bus.RegDst     = 2'b00;
    bus.MemToReg   = 2'b00;
`ifdef MIPS_MC_CTRL_ILLEGAL_EXC_EN
    bus.exc        = 1'b0;
`endif
    case (st)
      S_FETCH: begin
        bus.mem_req = 1'b1; bus.IRWrite = 1'b1; bus.PCWrite = 1'b1;
        bus.ALUSrcB = 2'b01; bus.ALUControl = ALUCTL_W'(A_ADD);
      end
      S_DECODE: begin
        bus.ALUSrcB = 2'b11; bus.ALUControl = ALUCTL_W'(A_ADD);
      end
      S_MEMADR, S_ADDIEX: begin
        bus.ALUSrcA = 1'b1; bus.ALUSrcB = 2'b10; bus.ALUControl = ALUCTL_W'(A_ADD);
      end
      S_MEMRD: begin
        bus.mem_req = 1'b1; bus.IorD = 1'b1;
      end
      S_MEMWB: begin
        bus.RegWrite = 1'b1; bus.MemToReg = 2'b01;
      end
      S_MEMWR: begin
        bus.mem_req = 1'b1; bus.MemWrite = 1'b1; bus.IorD = 1'b1;
      end
      S_EXEC: begin
        bus.ALUSrcA = 1'b1; bus.ALUControl = ALUCTL_W'(alu4);
      end
      S_ALUWB: begin
        bus.RegWrite = !alu_nop; bus.RegDst = 2'b01;
      end
      S_BRANCH: begin
        bus.ALUSrcA = 1'b1; bus.ALUControl = ALUCTL_W'(A_SUB);
        bus.Branch = 1'b1; bus.PCSrc = 2'b01;
      end
      S_ADDIWB: bus.RegWrite = 1'b1;
      S_JAL: begin
        bus.PCWrite = 1'b1; bus.PCSrc = 2'b10; bus.RegWrite = 1'b1;
        bus.RegDst = 2'b10; bus.MemToReg = 2'b10;
      end
      S_JR: begin
        bus.PCWrite = 1'b1; bus.PCSrc = 2'b11;
      end
`ifdef MIPS_MC_CTRL_ILLEGAL_EXC_EN
      S_TRAP: begin
        bus.PCWrite = 1'b1; bus.PCSrc = 2'b10; bus.exc = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign bus.mem_err = err;
  assign bus.state_o = st;
endmodule
